// File: rtl/pipe_mux.sv
// Parametrised operand select registered in a valid/ready stage.
// An output register plus a skid register decouple in_ready from out_ready.
module pipe_mux #(
  parameter int unsigned          WIDTH       = 32,
  parameter int unsigned          NUM_IN      = 4,
  parameter logic [WIDTH-1:0]     DEFAULT_VAL = '0,
  localparam int unsigned         SEL_W       = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  // Encoding mirrors (OR.valid, SK.valid).
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] or_data, sk_data, sel_data;
  logic             or_err, sk_err, sel_err;
  logic             accept;
  logic             or_load_in, or_load_sk, sk_load;

  always_comb begin
    sel_data = DEFAULT_VAL;
    sel_err  = 1'b1;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_data = in_data[k*WIDTH +: WIDTH];
        sel_err  = 1'b0;
      end
    end
  end

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_data  = or_data;
  assign out_err   = or_err;
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    or_load_in = 1'b0;
    or_load_sk = 1'b0;
    sk_load    = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          or_load_in = 1'b1;
          state_next = ONE;
        end
      end
      ONE: begin
        if (accept && out_ready) begin
          or_load_in = 1'b1;
        end else if (accept) begin
          sk_load    = 1'b1;
          state_next = FULL;
        end else if (out_ready) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (out_ready) begin
          or_load_sk = 1'b1;
          state_next = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_data <= '0;
      or_err  <= 1'b0;
      sk_data <= '0;
      sk_err  <= 1'b0;
    end else begin
      if (or_load_in) begin
        or_data <= sel_data;
        or_err  <= sel_err;
      end else if (or_load_sk) begin
        or_data <= sk_data;
        or_err  <= sk_err;
      end
      if (sk_load) begin
        sk_data <= sel_data;
        sk_err  <= sel_err;
      end
    end
  end

endmodule

// File: tb/tb_pipe_mux.sv
// Self-checking bench for pipe_mux: directed vector table, hand sequences
// for stall/reset corners, and a randomized run against a reference queue.
module tb_pipe_mux;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Instance A: NUM_IN=4, WIDTH=32
  logic [127:0] a_data;
  logic [1:0]   a_sel;
  logic         a_valid, a_ir, a_err, a_ov, a_rdy;
  logic [31:0]  a_out;

  pipe_mux #(.WIDTH(32), .NUM_IN(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_sel(a_sel),
    .in_valid(a_valid), .in_ready(a_ir), .out_data(a_out), .out_err(a_err),
    .out_valid(a_ov), .out_ready(a_rdy));

  // Instance C: NUM_IN=3, out-of-range select reachable
  logic [95:0]  c_data;
  logic [1:0]   c_sel;
  logic         c_valid, c_ir, c_err, c_ov, c_rdy;
  logic [31:0]  c_out;

  pipe_mux #(.WIDTH(32), .NUM_IN(3), .DEFAULT_VAL(32'h0000_0000)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_data(c_data), .in_sel(c_sel),
    .in_valid(c_valid), .in_ready(c_ir), .out_data(c_out), .out_err(c_err),
    .out_valid(c_ov), .out_ready(c_rdy));

  // Instance B: NUM_IN=5, WIDTH=16, randomized
  logic [79:0]  b_data;
  logic [2:0]   b_sel;
  logic         b_valid, b_ir, b_err, b_ov, b_rdy;
  logic [15:0]  b_out;

  pipe_mux #(.WIDTH(16), .NUM_IN(5), .DEFAULT_VAL(16'hDEAD)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_sel(b_sel),
    .in_valid(b_valid), .in_ready(b_ir), .out_data(b_out), .out_err(b_err),
    .out_valid(b_ov), .out_ready(b_rdy));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_a_ops();
    a_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  endtask

  task automatic a_step(input logic v, input logic [1:0] s, input logic r);
    a_valid = v; a_sel = s; a_rdy = r;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        v;
    logic [1:0]  sel;
    logic        rdy;
    logic        ov;
    logic [31:0] d;
    logic        err;
    logic        ir;
  } vec_t;

  vec_t tbl[10];

  logic [16:0] q[$];
  logic [16:0] exp_e;
  logic        acc_prev;

  initial begin
    // Stream: sel 0..3 with out_ready held, then idle.
    tbl[0] = '{1'b1, 2'd0, 1'b1, 1'b1, 32'h11111111, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 2'd1, 1'b1, 1'b1, 32'h22222222, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 2'd2, 1'b1, 1'b1, 32'h33333333, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 2'd3, 1'b1, 1'b1, 32'h44444444, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 2'd0, 1'b1, 1'b0, 32'h44444444, 1'b0, 1'b1};
    // Back-pressure: sel2 accepted, sel3 to skid, blocked offer, drain.
    tbl[5] = '{1'b1, 2'd2, 1'b1, 1'b1, 32'h33333333, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 2'd3, 1'b0, 1'b1, 32'h33333333, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 2'd0, 1'b0, 1'b1, 32'h33333333, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 2'd0, 1'b1, 1'b1, 32'h44444444, 1'b0, 1'b1};
    tbl[9] = '{1'b0, 2'd0, 1'b1, 1'b0, 32'h44444444, 1'b0, 1'b1};

    set_a_ops();
    a_sel = '0; a_valid = 1'b0; a_rdy = 1'b0;
    c_data = {32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
    c_sel = '0; c_valid = 1'b0; c_rdy = 1'b0;
    b_data = '0; b_sel = '0; b_valid = 1'b0; b_rdy = 1'b0;

    #12;
    chk("reset_ov", {31'b0, a_ov}, 32'd0);
    chk("reset_data", a_out, 32'd0);
    chk("reset_err", {31'b0, a_err}, 32'd0);
    chk("reset_ir", {31'b0, a_ir}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      a_step(tbl[i].v, tbl[i].sel, tbl[i].rdy);
      chk($sformatf("vec%0d_ov", i), {31'b0, a_ov}, {31'b0, tbl[i].ov});
      chk($sformatf("vec%0d_ir", i), {31'b0, a_ir}, {31'b0, tbl[i].ir});
      if (tbl[i].ov) begin
        chk($sformatf("vec%0d_data", i), a_out, tbl[i].d);
        chk($sformatf("vec%0d_err", i), {31'b0, a_err}, {31'b0, tbl[i].err});
      end
    end
    chk("hold_after_idle", a_out, 32'h44444444);

    // Stability while FULL with out_ready low and inputs churning.
    a_step(1'b1, 2'd0, 1'b0);
    a_step(1'b1, 2'd1, 1'b0);
    chk("stall_full_ir", {31'b0, a_ir}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 4; k++) a_data[k*32 +: 32] = $urandom;
      a_step(1'b1, 2'($urandom_range(0, 3)), 1'b0);
      chk($sformatf("stall%0d_data", i), a_out, 32'h11111111);
      chk($sformatf("stall%0d_err", i), {31'b0, a_err}, 32'd0);
      chk($sformatf("stall%0d_ov", i), {31'b0, a_ov}, 32'd1);
      chk($sformatf("stall%0d_ir", i), {31'b0, a_ir}, 32'd0);
    end
    set_a_ops();
    a_step(1'b0, 2'd0, 1'b1);
    chk("stall_drain_sk", a_out, 32'h22222222);
    chk("stall_drain_ov", {31'b0, a_ov}, 32'd1);
    a_step(1'b0, 2'd0, 1'b1);
    chk("stall_drain_empty", {31'b0, a_ov}, 32'd0);

    // Asynchronous reset while FULL.
    a_step(1'b1, 2'd2, 1'b0);
    a_step(1'b1, 2'd3, 1'b0);
    chk("prereset_full", {31'b0, a_ir}, 32'd0);
    a_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ov", {31'b0, a_ov}, 32'd0);
    chk("async_rst_data", a_out, 32'd0);
    chk("async_rst_err", {31'b0, a_err}, 32'd0);
    chk("async_rst_ir", {31'b0, a_ir}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    a_step(1'b0, 2'd0, 1'b1);
    chk("post_rst_idle_ov", {31'b0, a_ov}, 32'd0);
    chk("post_rst_idle_ir", {31'b0, a_ir}, 32'd1);
    a_step(1'b1, 2'd1, 1'b1);
    chk("post_rst_first_ov", {31'b0, a_ov}, 32'd1);
    chk("post_rst_first_data", a_out, 32'h22222222);
    a_step(1'b0, 2'd0, 1'b1);
    chk("post_rst_alone", {31'b0, a_ov}, 32'd0);

    // Out-of-range select on NUM_IN=3.
    c_valid = 1'b1; c_sel = 2'd3; c_rdy = 1'b1;
    @(posedge clk); #1;
    chk("oor_ov", {31'b0, c_ov}, 32'd1);
    chk("oor_data", c_out, 32'h0);
    chk("oor_err", {31'b0, c_err}, 32'd1);
    c_sel = 2'd1;
    @(posedge clk); #1;
    chk("inrange1_data", c_out, 32'hBBBBBBBB);
    chk("inrange1_err", {31'b0, c_err}, 32'd0);
    c_sel = 2'd2;
    @(posedge clk); #1;
    chk("inrange2_data", c_out, 32'hCCCCCCCC);
    chk("inrange2_err", {31'b0, c_err}, 32'd0);
    c_valid = 1'b0;
    @(posedge clk); #1;
    chk("oor_done_ov", {31'b0, c_ov}, 32'd0);

    // Randomized valid/ready against an ordered reference queue.
    acc_prev = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if (acc_prev || !b_valid) begin
        b_valid = ($urandom_range(0, 9) < 7);
        b_sel = 3'($urandom_range(0, 7));
        for (int k = 0; k < 5; k++) b_data[k*16 +: 16] = 16'($urandom);
      end
      b_rdy = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      chk("rnd_ir", {31'b0, b_ir}, {31'b0, (q.size() < 2)});
      chk("rnd_ov", {31'b0, b_ov}, {31'b0, (q.size() > 0)});
      if (b_ov && b_rdy) begin
        if (q.size() == 0) begin
          chk("rnd_underflow", 32'd1, 32'd0);
        end else begin
          exp_e = q.pop_front();
          chk("rnd_data", {16'b0, b_out}, {16'b0, exp_e[15:0]});
          chk("rnd_err", {31'b0, b_err}, {31'b0, exp_e[16]});
        end
      end
      acc_prev = b_valid && b_ir;
      if (acc_prev) begin
        if (b_sel < 3'd5) q.push_back({1'b0, b_data[b_sel*16 +: 16]});
        else              q.push_back({1'b1, 16'hDEAD});
      end
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_mux.md
Name: pipe_mux

Overview:
- Parametrised successor to the processor's combinational 2:1 word select.
- Selects one of NUM_IN WIDTH-bit operands and registers the result in a valid/ready pipeline stage.
- A 2-entry skid buffer sustains full throughput while keeping in_ready off the combinational downstream path.
- Used between pipeline stages for operand/forwarding selection where a stall can back-pressure the producer.

Parameters:
- WIDTH, 32, data width in bits of every input and the output.
- NUM_IN, 4, number of data inputs (legal range 2..16).
- SEL_W, $clog2(NUM_IN), select width (derived, not overridden).
- DEFAULT_VAL, 32'h0000_0000, WIDTH-bit value output when sel >= NUM_IN.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  NUM_IN*WIDTH  flattened operands; operand k = in_data[k*WIDTH +: WIDTH].
- in_sel  input  SEL_W  operand index, sampled together with in_data.
- in_valid  input  1  producer offers in_data/in_sel this cycle.
- in_ready  output  1  block can accept this cycle.
- out_data  output  WIDTH  selected operand.
- out_err  output  1  set when the transfer carried an out-of-range select.
- out_valid  output  1  out_data/out_err valid.
- out_ready  input  1  consumer accepts this cycle.

Behaviour:
- One clock, reset asynchronous active-low. Reset clears all state immediately:
  - out_valid=0, out_data=0, out_err=0.
  - skid buffer empty; in_ready=1.
- Any transfer in flight at reset is dropped; nothing is replayed after rst_n rises.
- Accept condition: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Selection is evaluated at accept time and the result is stored; later changes to in_data/in_sel do not affect stored entries.
  - If in_sel < NUM_IN, the stored value is operand in_sel with err=0.
  - Otherwise the stored value is DEFAULT_VAL with err=1.
- Storage is an output register (OR) plus a skid register (SK).
- in_ready = !SK.valid, driven from a register only; no combinational path from out_ready.
- Latency: accept in cycle N gives out_valid=1 in cycle N+1 when OR is empty or draining. Throughput is 1 transfer per cycle when out_ready is held 1.
- States, encoded as (OR.valid, SK.valid):
  - EMPTY (0,0): accept -> ONE.
  - ONE (1,0):
    - accept with out_ready -> OR reloads from input, stays ONE.
    - accept without out_ready -> input goes to SK, -> FULL.
    - out_ready without accept -> EMPTY.
    - neither -> hold.
  - FULL (1,1): in_ready=0, no accept possible.
    - out_ready -> OR loads from SK, SK clears, -> ONE.
    - otherwise hold.
- Simultaneous accept and output transfer in ONE: the new value replaces OR; no bubble and no loss.
- Order is strictly FIFO; no entry is duplicated or dropped.
- While out_valid=1 and out_ready=0, out_data and out_err are stable.
- in_valid without in_ready is not an accept; the producer must hold its offer, and the block does not check this.
- When out_valid=0, out_data and out_err hold their last value; the value is meaningful only while out_valid=1.

Test Plan:
- Reset then stream: NUM_IN=4; operands 0..3 = 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444; out_ready=1; in_valid=1 with in_sel 0,1,2,3 on consecutive cycles -> out_data 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444 on cycles 1-4 after the first accept, out_valid continuous, out_err=0.
- Back-pressure: out_ready=0 from the cycle after the first accept, offering sel=2 then sel=3 -> OR holds 32'h33333333, SK holds 32'h44444444, in_ready drops to 0 on the next cycle. Raise out_ready -> 32'h33333333 then 32'h44444444 emitted; in_ready returns to 1 one cycle after the first drain.
- Out-of-range select: NUM_IN=3, in_sel=3 accepted -> out_data=DEFAULT_VAL (32'h0), out_err=1. The next in_sel=1 transfer -> out_err=0.
- Stability under stall: change in_data every cycle while FULL and out_ready=0 for 5 cycles -> out_data and out_err unchanged; no accept; no entry lost.
- Reset mid-operation: assert rst_n=0 asynchronously while FULL -> out_valid=0, out_data=0, out_err=0 without a clock edge; after release in_ready=1 and the first new transfer appears alone on the output.
- Random valid/ready (10k cycles, NUM_IN=5, WIDTH=16) against a reference queue -> identical ordered sequence of (out_data, out_err); in_ready never 1 while the skid is occupied.
